// File: rtl/histogram_pkg.sv
// rtl/histogram_pkg.sv - shared histogram types and default sizes
// Holds the control state encoding, bin index width and default geometry
// used by the accumulator and the bin-mapping stage.
package histogram_pkg;

  localparam int hist_idx_w              = 8;
  localparam int hist_default_bins       = 30;
  localparam int hist_default_count_bits = 16;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_accum = 2'd1,
    st_dump  = 2'd2
  } hist_state_e;

endpackage

// File: rtl/hist_sat_counter.sv
// rtl/hist_sat_counter.sv - saturating bin counter with synchronous clear
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one (ignored at full scale)
//   clr        : synchronous clear, wins over inc
//   count      : current count
module hist_sat_counter #(
  parameter int p_count_bits = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    clr,
  output logic [p_count_bits-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/histogram_accumulator.sv
// rtl/histogram_accumulator.sv - framed histogram accumulator with bin dump
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   data_in, valid_in       : sample bin index and its qualifier
//   sof_in                  : sample opens a new frame
//   flush_in                : dump the open frame without a following sof
//   busy_out                : sample not accepted this cycle
//   data_out, valid_out     : bin count stream
//   sof_out, eof_out        : first / last bin marker
//   busy_in                 : downstream stall
module histogram_accumulator
  import histogram_pkg::*;
#(
  parameter int p_bins       = hist_default_bins,
  parameter int p_count_bits = hist_default_count_bits
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [hist_idx_w-1:0]   data_in,
  input  logic                    valid_in,
  input  logic                    sof_in,
  output logic                    busy_out,
  input  logic                    flush_in,
  output logic [p_count_bits-1:0] data_out,
  output logic                    valid_out,
  output logic                    sof_out,
  output logic                    eof_out,
  input  logic                    busy_in
);

  localparam logic [hist_idx_w-1:0] last_bin = hist_idx_w'(p_bins - 1);

  hist_state_e state_q, next_state;

  // Set when the dump was triggered by a new sof: the held sample is then
  // taken as the first of the next frame instead of re-triggering a dump.
  logic                    sof_pend_q;
  logic                    dump_by_sof;
  logic [hist_idx_w-1:0]   rd_idx_q;
  logic [hist_idx_w-1:0]   out_idx_q;
  logic [p_count_bits-1:0] rd_count;
  logic [p_count_bits-1:0] counts [p_bins];
  logic                    accept;
  logic                    count_en;
  logic                    xfer;
  logic                    load;

  always_comb begin
    next_state  = state_q;
    busy_out    = 1'b0;
    dump_by_sof = 1'b0;
    case (state_q)
      st_idle: begin
        if (valid_in && sof_in) next_state = st_accum;
      end
      st_accum: begin
        if (valid_in && sof_in && !sof_pend_q) begin
          busy_out    = 1'b1;
          dump_by_sof = 1'b1;
          next_state  = st_dump;
        end else if (flush_in) begin
          next_state = st_dump;
        end
      end
      st_dump: begin
        busy_out = 1'b1;
        if (valid_out && !busy_in && eof_out)
          next_state = sof_pend_q ? st_accum : st_idle;
      end
      default: next_state = st_idle;
    endcase
  end

  assign accept   = valid_in && !busy_out;
  // In IDLE only a sof sample is counted; out-of-range indices are dropped.
  assign count_en = accept && (data_in <= last_bin) && ((state_q == st_accum) || sof_in);
  assign xfer     = valid_out && !busy_in;
  assign load     = (state_q == st_dump) && (rd_idx_q <= last_bin) && (!valid_out || !busy_in);

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < p_bins; i++) begin
      if (rd_idx_q == hist_idx_w'(i)) rd_count = counts[i];
    end
  end

  for (genvar g = 0; g < p_bins; g++) begin : g_bin
    localparam logic [hist_idx_w-1:0] bin_idx = hist_idx_w'(g);
    hist_sat_counter #(.p_count_bits(p_count_bits)) u_cnt (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .inc   (count_en && (data_in == bin_idx)),
      .clr   (xfer && (out_idx_q == bin_idx)),
      .count (counts[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= st_idle;
      sof_pend_q <= 1'b0;
    end else begin
      state_q <= next_state;
      if (state_q == st_accum) begin
        if (next_state == st_dump) sof_pend_q <= dump_by_sof;
        else if (accept)           sof_pend_q <= 1'b0;
      end else if (state_q == st_idle) begin
        sof_pend_q <= 1'b0;
      end
    end
  end

  // Registered output stage: the next bin is fetched whenever the output
  // register is empty or being drained, giving one word per cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_idx_q  <= '0;
      out_idx_q <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      eof_out   <= 1'b0;
    end else begin
      if (load) begin
        data_out  <= rd_count;
        valid_out <= 1'b1;
        sof_out   <= (rd_idx_q == '0);
        eof_out   <= (rd_idx_q == last_bin);
        out_idx_q <= rd_idx_q;
        rd_idx_q  <= rd_idx_q + 1'b1;
      end else if (xfer) begin
        data_out  <= '0;
        valid_out <= 1'b0;
        sof_out   <= 1'b0;
        eof_out   <= 1'b0;
      end
      if (state_q != st_dump) rd_idx_q <= '0;
    end
  end

endmodule

// File: tb/tb_histogram_accumulator.sv
// tb/tb_histogram_accumulator.sv - directed self-checking bench for histogram_accumulator
module tb_histogram_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        valid_in, sof_in, flush_in, busy_in;
  logic        busy_out, valid_out, sof_out, eof_out;
  logic [15:0] data_out;
  logic        busy_out4, valid_out4, sof_out4, eof_out4;
  logic [3:0]  data_out4;

  int total = 0;
  int passed = 0;
  logic [17:0] words[$];
  logic [3:0]  words4[$];
  int exp_bins[30];

  always #5 clk = ~clk;

  histogram_accumulator dut (
    .i_clk(clk), .i_rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .sof_in(sof_in), .busy_out(busy_out), .flush_in(flush_in),
    .data_out(data_out), .valid_out(valid_out), .sof_out(sof_out),
    .eof_out(eof_out), .busy_in(busy_in)
  );

  histogram_accumulator #(.p_count_bits(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .sof_in(sof_in), .busy_out(busy_out4), .flush_in(flush_in),
    .data_out(data_out4), .valid_out(valid_out4), .sof_out(sof_out4),
    .eof_out(eof_out4), .busy_in(busy_in)
  );

  // Record every transferred word; sampled mid-cycle, transfer on next edge.
  always @(negedge clk) begin
    if (rst_n && valid_out && !busy_in) words.push_back({sof_out, eof_out, data_out});
    if (rst_n && valid_out4 && !busy_in) words4.push_back(data_out4);
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 30; i++) exp_bins[i] = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic s, output int waited);
    waited = 0;
    data_in = d; sof_in = s; valid_in = 1'b1;
    @(negedge clk);
    while (busy_out && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) check("send_timeout", 32'(waited), 0);
    @(posedge clk); #1;
    valid_in = 1'b0; sof_in = 1'b0; data_in = '0;
  endtask

  task automatic flush();
    flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (words.size() < n && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_words", 32'(words.size() >= n), 1);
  endtask

  task automatic check_dump(input string tag);
    check({tag, "_len"}, 32'(words.size()), 30);
    for (int i = 0; i < 30 && i < words.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(words[i]),
            32'({i == 0, i == 29, 16'(exp_bins[i])}));
  endtask

  initial begin
    int w;
    rst_n = 1'b0; data_in = '0; valid_in = 1'b0; sof_in = 1'b0;
    flush_in = 1'b0; busy_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid_out", 32'(valid_out), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_sof_eof", 32'({sof_out, eof_out}), 0);
    check("rst_busy_out", 32'(busy_out), 0);
    check("rst_valid_out4", 32'(valid_out4), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame {0,0,3,29}; a second sof closes it and is held through the dump.
    send(8'd0, 1'b1, w); check("idle_sof_wait", 32'(w), 0);
    send(8'd0, 1'b0, w);
    send(8'd3, 1'b0, w);
    send(8'd29, 1'b0, w);
    words.delete();
    send(8'd5, 1'b1, w);
    check("held_sof_busy_cycles", 32'(w), 32);
    clear_exp(); exp_bins[0] = 2; exp_bins[3] = 1; exp_bins[29] = 1;
    check_dump("frame1");

    // Held sample plus bin7 x2; flush, stall 5 cycles with bin 7 on the output.
    send(8'd7, 1'b0, w);
    send(8'd7, 1'b0, w);
    words.delete();
    flush();
    begin
      int k = 0;
      while (words.size() < 7 && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      check("stall_reach_bin7", 32'(words.size()), 7);
    end
    busy_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_hold_%0d", i), 32'({valid_out, sof_out, eof_out, data_out}),
            32'({3'b100, 16'd2}));
    end
    @(posedge clk); #1;
    busy_in = 1'b0;
    wait_words(30);
    clear_exp(); exp_bins[5] = 1; exp_bins[7] = 2;
    check_dump("frame2");

    // IDLE: non-sof sample discarded; out-of-range samples dropped.
    @(posedge clk); #1;
    send(8'd9, 1'b0, w); check("idle_nosof_wait", 32'(w), 0);
    words.delete();
    send(8'd200, 1'b1, w);
    send(8'd30, 1'b0, w);
    flush();
    wait_words(30);
    clear_exp();
    check_dump("frame_oor");

    // Saturation on the 4-bit instance: 20 samples to bin 5.
    @(posedge clk); #1;
    words.delete(); words4.delete();
    send(8'd5, 1'b1, w);
    for (int i = 0; i < 19; i++) send(8'd5, 1'b0, w);
    flush();
    wait_words(30);
    check("sat_len4", 32'(words4.size()), 30);
    for (int i = 0; i < 30 && i < words4.size(); i++)
      check($sformatf("sat4[%0d]", i), 32'(words4[i]), (i == 5) ? 32'd15 : 32'd0);
    check("sat16_bin5", (words.size() > 5) ? 32'(words[5][15:0]) : 32'hdead, 20);

    // Back in IDLE: a plain sample and a flush produce nothing.
    @(posedge clk); #1;
    words.delete();
    send(8'd5, 1'b0, w); check("idle_after_flush_wait", 32'(w), 0);
    flush();
    repeat (40) @(posedge clk);
    #1;
    check("idle_no_dump", 32'(words.size()), 0);
    check("idle_busy_out", 32'(busy_out), 0);

    // Reset while bin 12 is on the output.
    send(8'd4, 1'b1, w);
    flush();
    begin
      int k = 0;
      while (words.size() < 12 && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      check("rst_reach_bin12", 32'({valid_out, 8'(words.size())}), 32'({1'b1, 8'd12}));
    end
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", 32'(valid_out), 0);
    check("midrst_outputs", 32'({busy_out, sof_out, eof_out, data_out}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    words.delete();
    send(8'd1, 1'b1, w);
    flush();
    wait_words(30);
    clear_exp(); exp_bins[1] = 1;
    check_dump("frame_after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/histogram_accumulator.md
HISTOGRAM_ACCUMULATOR -- requirements
Module: histogram_accumulator

Interface
REQ-001 The block SHALL have parameter p_bins, default 30, meaning the number of histogram bins (range 1..255).
REQ-002 The block SHALL have parameter p_count_bits, default 16, meaning the width of each bin counter.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_in, input, 8 bits: bin index of the incoming sample.
REQ-006 The block SHALL have port valid_in, input, 1 bit: data_in is valid.
REQ-007 The block SHALL have port sof_in, input, 1 bit: the current sample is the first of a frame; qualified by valid_in.
REQ-008 The block SHALL have port busy_out, output, 1 bit: sample not accepted this cycle.
REQ-009 The block SHALL have port flush_in, input, 1 bit: single-cycle request to dump the current frame without a following sof.
REQ-010 The block SHALL have port data_out, output, p_count_bits bits: bin count.
REQ-011 The block SHALL have port valid_out, output, 1 bit: data_out is valid.
REQ-012 The block SHALL have port sof_out, output, 1 bit: data_out is bin 0.
REQ-013 The block SHALL have port eof_out, output, 1 bit: data_out is bin p_bins-1.
REQ-014 The block SHALL have port busy_in, input, 1 bit: downstream stall.

Function
REQ-015 Acceptance SHALL occur when valid_in=1 and busy_out=0 in the same cycle.
REQ-016 States SHALL be IDLE (no frame open), ACCUM (frame open) and DUMP (emitting counts).
REQ-017 IDLE: busy_out=0; accepted samples without sof_in are discarded; an accepted sample with sof_in=1 opens a frame, counts it, and moves to ACCUM.
REQ-018 ACCUM: each accepted sample with data_in < p_bins increments counter[data_in] by 1, visible one cycle later.
REQ-019 Counters SHALL saturate at 2^p_count_bits-1.
REQ-020 Samples with data_in >= p_bins SHALL be accepted and dropped, with no counter change.
REQ-021 Back-to-back samples to the same bin SHALL each count (no read-modify-write loss).
REQ-022 ACCUM with valid_in=1 and sof_in=1: busy_out=1 combinationally, the sample is not accepted, and the state moves to DUMP; after the dump, ACCUM accepts it as the first sample of the new frame.
REQ-023 ACCUM with flush_in=1 moves to DUMP; after the dump the state is IDLE.
REQ-024 flush_in in IDLE or DUMP SHALL be ignored.
REQ-025 DUMP: busy_out=1; bins 0..p_bins-1 are emitted in order, one per cycle while busy_in=0; the first valid_out occurs one cycle after entering DUMP.
REQ-026 While valid_out=1 and busy_in=1, data_out, sof_out and eof_out SHALL hold stable.
REQ-027 Each bin SHALL be cleared to 0 in the cycle its count is transferred (valid_out=1 and busy_in=0).
REQ-028 After the eof_out transfer, the state SHALL move to ACCUM (sof pending) or IDLE (flush) on the next cycle, with valid_out=0.
REQ-029 An empty frame SHALL still dump p_bins zero counts.

Reset
REQ-030 On i_rst_n=0, at any time including mid-DUMP, the block SHALL enter IDLE with all counters=0, data_out=0, valid_out=0, sof_out=0, eof_out=0 and busy_out=0; the partial dump is abandoned.
REQ-031 After reset release, the first accepted sample with sof_in=1 SHALL open a frame.

Structure
REQ-032 A shared package histogram_pkg SHALL hold the state enumeration, the 8-bit bin index width and the default p_bins/p_count_bits constants, shared with the bin-mapping stage.
REQ-033 The block SHALL contain one sub-module, hist_sat_counter (p_count_bits-wide saturating counter with increment and synchronous clear), instantiated p_bins times.

Verification
REQ-034 Bench SHALL cover: sof+bins {0,0,3,29}, then sof -> dump of 30 words: bin0=2, bin3=1, bin29=1, others 0; sof_out on word 0, eof_out on word 29.
REQ-035 Bench SHALL cover: busy_in=1 for 5 cycles mid-dump at bin 7 -> bin 7 held for all 5 cycles, no bins skipped or repeated.
REQ-036 Bench SHALL cover: p_count_bits=4, 20 samples to bin 5, then flush -> bin5=15, state IDLE afterwards.
REQ-037 Bench SHALL cover: frame with data_in=200 and 30 -> no counts; dump is all zeros.
REQ-038 Bench SHALL cover: i_rst_n low while emitting bin 12 -> valid_out=0 immediately; a next frame with 1 sample in bin 1 dumps bin1=1, all others 0.
REQ-039 Bench SHALL cover: second sof during ACCUM -> busy_out=1 throughout the dump; the held sample is counted in the next frame's dump.
